updsllr_qpsk_llr_calc: RTL and testbench
========================================

Name: updsllr_qpsk_llr_calc

Overview:
Downstream stage of the slow-PHY-to-LLR reader; consumes its strobed RE-pair plus noise samples and produces per-bit QPSK soft LLRs. Each strobe carries two REs (I/Q each) and one noise scale word. Each component is scaled by the noise word, shifted, saturated to LLR_W bits, and packed into one output word. Counts REs per user and flags the last output of the user allocation.

Parameters:
DATA_W, 16, width of I/Q samples (signed) and noise scale (unsigned)
LLR_W, 8, width of each output LLR (signed, two's complement)
LLR_SHIFT, 10, arithmetic right shift applied to the product before saturation

Ports:
i_core_clk  input  1  core clock, all logic on rising edge
i_rx_rst  input  1  synchronous active-high reset
i_start  input  1  one-cycle pulse; latches i_cur_user_re_amounts, arms block
i_cur_user_re_amounts  input  16  REs in current user allocation (≥1)
i_data_strobe  input  1  RE-pair valid, driven by reader's o_data_strobe
i_re0_data_i  input  DATA_W  RE0 in-phase, signed
i_re0_data_q  input  DATA_W  RE0 quadrature, signed
i_re1_data_i  input  DATA_W  RE1 in-phase, signed
i_re1_data_q  input  DATA_W  RE1 quadrature, signed
i_noise_data  input  DATA_W  noise-derived scale, unsigned, shared by both REs
o_llr_valid  output  1  o_llr_data valid this cycle
o_llr_data  output  4*LLR_W  packed LLRs: [LLR_W-1:0]=re0_i, next=re0_q, next=re1_i, top=re1_q
o_llr_last  output  1  qualifies o_llr_valid; final word of the user
o_busy  output  1  high from i_start until o_llr_last is emitted

Behaviour:
- Reset (sync, high): all outputs 0, state IDLE, RE counter 0, pipeline valids cleared. Reset mid-user discards all in-flight data; no o_llr_valid or o_llr_last after reset until a new i_start.
- FSM IDLE -> RUN on i_start. In the start cycle: latch amount, clear counter, set o_busy.
- IDLE strobes are ignored, including a strobe coincident with i_start.
- RUN: each i_data_strobe accepts a pair and adds 2 to the counter. The strobe that brings the counter to ≥ latched amount is the last strobe; FSM -> DRAIN.
- DRAIN: strobes ignored. When the last word's o_llr_valid/o_llr_last fires, -> IDLE and o_busy drops in the same cycle.
- i_start outside IDLE is ignored.
- Odd amount: in the last strobe's word, re1 LLR fields are forced to 0.
- Arithmetic per component: product = signed(x) * {1'b0, noise}, full 2*DATA_W+1 bits.
  - Then arithmetic shift right by LLR_SHIFT (floor; no rounding).
  - Then saturate to [-(2^(LLR_W-1)), 2^(LLR_W-1)-1].
- Pipeline: stage 1 registers the four products; stage 2 registers shift+saturate; stage 3 is the output register.
- Latency is fixed at 3 cycles from strobe to o_llr_valid. Back-to-back strobes give back-to-back outputs; no backpressure.
- o_llr_last is asserted only with o_llr_valid, on the word from the last strobe.
- o_llr_data holds its last value when o_llr_valid=0.

Optional Feature:
UPDSLLR_SAT_CNT_EN:
- Defined: adds output port o_sat_cnt (16 bits).
  - Counts LLR components clipped by saturation, up to 4 per word.
  - Sticks at 0xFFFF; cleared on reset and on i_start.
  - Forced-zero re1 fields never count.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic: reset, i_start, amount=2, one strobe with re0_i=0x0100, re0_q=0xFF00, re1_i=0x0000, re1_q=0x0040, noise=0x0080 -> 3 cycles later o_llr_valid=1, o_llr_last=1, o_llr_data=0x08_00_E0_20; o_busy falls that cycle.
- Saturation: re0_i=0x7FFF, re0_q=0x8000, re1_i=0x0001, re1_q=0xFFFF, noise=0xFFFF -> fields 0x7F, 0x80, 0x3F, 0xC0 (floor); with UPDSLLR_SAT_CNT_EN, o_sat_cnt=2.
- Streaming: amount=1800, 900 consecutive strobes -> 900 consecutive o_llr_valid; o_llr_last only on the 900th; counter ends at 1800.
- Odd amount: amount=3, two strobes, all inputs 0x0100, noise 0x0080 -> second word = 0x0000_2020 with o_llr_last=1.
- Ignored input: strobes in IDLE, in DRAIN, and coincident with i_start -> no o_llr_valid generated; second i_start while RUN does not change the latched amount.
- Reset mid-operation: assert i_rx_rst one cycle after a strobe in RUN -> no o_llr_valid appears; outputs 0; a new i_start restarts cleanly.

Source files
------------

// File: rtl/updsllr_qpsk_llr_calc.sv
// QPSK soft-LLR calculator: scales each RE-pair component by the noise word, shifts,
// saturates and packs four LLRs per strobe. Optional saturation counter: UPDSLLR_SAT_CNT_EN.

module updsllr_qpsk_llr_lane #(
    parameter int DATA_W    = 16,
    parameter int LLR_W     = 8,
    parameter int LLR_SHIFT = 10
) (
    input  logic                     clk,
    input  logic                     s1_en,
    input  logic                     s2_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic        [DATA_W-1:0] noise,
    output logic        [LLR_W-1:0]  llr
`ifdef UPDSLLR_SAT_CNT_EN
    ,
    output logic                     sat
`endif
);
    localparam int PW = 2*DATA_W + 1;
    localparam logic signed [PW-1:0] LLR_MAX = PW'((2**(LLR_W-1)) - 1);
    localparam logic signed [PW-1:0] LLR_MIN = ~LLR_MAX;

    logic signed [PW-1:0] x_ext, n_ext, prod_d, prod_q, sh;
    logic        [LLR_W-1:0] llr_d, llr_q;
    logic                    sat_d;

    always_comb begin
        x_ext  = PW'(x);
        n_ext  = PW'({1'b0, noise});
        prod_d = x_ext * n_ext;
        // Arithmetic shift floors toward -inf; no rounding term is added.
        sh     = prod_q >>> LLR_SHIFT;
        llr_d  = sh[LLR_W-1:0];
        sat_d  = 1'b0;
        if (sh > LLR_MAX) begin
            llr_d = LLR_MAX[LLR_W-1:0];
            sat_d = 1'b1;
        end else if (sh < LLR_MIN) begin
            llr_d = LLR_MIN[LLR_W-1:0];
            sat_d = 1'b1;
        end
    end

`ifdef UPDSLLR_SAT_CNT_EN
    logic sat_q;
    always_ff @(posedge clk) begin
        if (s2_en) sat_q <= sat_d;
    end
    assign sat = sat_q;
`else
    logic sat_unused;
    assign sat_unused = sat_d;
`endif

    always_ff @(posedge clk) begin
        if (s1_en) prod_q <= prod_d;
        if (s2_en) llr_q  <= llr_d;
    end

    assign llr = llr_q;
endmodule

module updsllr_qpsk_llr_calc #(
    parameter int DATA_W    = 16,
    parameter int LLR_W     = 8,
    parameter int LLR_SHIFT = 10
) (
    input  logic                 i_core_clk,
    input  logic                 i_rx_rst,
    input  logic                 i_start,
    input  logic [15:0]          i_cur_user_re_amounts,
    input  logic                 i_data_strobe,
    input  logic [DATA_W-1:0]    i_re0_data_i,
    input  logic [DATA_W-1:0]    i_re0_data_q,
    input  logic [DATA_W-1:0]    i_re1_data_i,
    input  logic [DATA_W-1:0]    i_re1_data_q,
    input  logic [DATA_W-1:0]    i_noise_data,
    output logic                 o_llr_valid,
    output logic [4*LLR_W-1:0]   o_llr_data,
    output logic                 o_llr_last,
    output logic                 o_busy
`ifdef UPDSLLR_SAT_CNT_EN
    ,
    output logic [15:0]          o_sat_cnt
`endif
);
    localparam int NUM_LANES = 4;
    localparam int STAGES    = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [15:0]           amount_q, amount_d;
    logic [16:0]           cnt_q, cnt_d;
    logic                  acc, last_acc, start_acc;
    logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
    logic [STAGES:1]       last_pipe_q, last_pipe_d;
    logic [STAGES-1:1]     zero_pipe_q, zero_pipe_d;
    logic [4*LLR_W-1:0]    llr_data_q, llr_data_d;

    logic [NUM_LANES-1:0][DATA_W-1:0] lane_x;
    logic [NUM_LANES-1:0][LLR_W-1:0]  lane_llr;

    assign lane_x = {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i};

    // Counter is one bit wider than the amount so +2 can never wrap past it.
    always_comb begin
        state_d   = state_q;
        amount_d  = amount_q;
        cnt_d     = cnt_q;
        acc       = 1'b0;
        last_acc  = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    amount_d  = i_cur_user_re_amounts;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (i_data_strobe) begin
                    acc   = 1'b1;
                    cnt_d = cnt_q + 17'd2;
                    if (cnt_d >= {1'b0, amount_q}) begin
                        last_acc = 1'b1;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld_pipe_q[STAGES-1] && last_pipe_q[STAGES-1]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_pipe_d  = {vld_pipe_q[STAGES-1:1], acc};
        last_pipe_d = {last_pipe_q[STAGES-1:1], last_acc};
        zero_pipe_d = {zero_pipe_q[STAGES-2:1], last_acc & amount_q[0]};
        llr_data_d  = llr_data_q;
        if (vld_pipe_q[STAGES-1]) begin
            llr_data_d = lane_llr;
            // Odd allocation: the final pair carries only one real RE.
            if (zero_pipe_q[STAGES-1]) llr_data_d[4*LLR_W-1:2*LLR_W] = '0;
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q     <= IDLE;
            amount_q    <= '0;
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            zero_pipe_q <= '0;
            llr_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            amount_q    <= amount_d;
            cnt_q       <= cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            zero_pipe_q <= zero_pipe_d;
            llr_data_q  <= llr_data_d;
        end
    end

`ifdef UPDSLLR_SAT_CNT_EN
    logic [NUM_LANES-1:0] lane_sat;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        updsllr_qpsk_llr_lane #(
            .DATA_W    (DATA_W),
            .LLR_W     (LLR_W),
            .LLR_SHIFT (LLR_SHIFT)
        ) u_lane (
            .clk   (i_core_clk),
            .s1_en (acc),
            .s2_en (vld_pipe_q[1]),
            .x     (lane_x[g]),
            .noise (i_noise_data),
            .llr   (lane_llr[g])
`ifdef UPDSLLR_SAT_CNT_EN
            ,
            .sat   (lane_sat[g])
`endif
        );
    end

`ifdef UPDSLLR_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic [2:0]  sat_inc;
    logic [16:0] sat_sum;

    always_comb begin
        sat_inc = 3'(lane_sat[0]) + 3'(lane_sat[1]);
        if (!zero_pipe_q[STAGES-1]) sat_inc = sat_inc + 3'(lane_sat[2]) + 3'(lane_sat[3]);
        sat_sum   = {1'b0, sat_cnt_q} + 17'(sat_inc);
        sat_cnt_d = sat_cnt_q;
        if (start_acc) begin
            sat_cnt_d = '0;
        end else if (vld_pipe_q[STAGES-1]) begin
            sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) sat_cnt_q <= '0;
        else          sat_cnt_q <= sat_cnt_d;
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

    assign o_llr_valid = vld_pipe_q[STAGES];
    assign o_llr_last  = last_pipe_q[STAGES];
    assign o_llr_data  = llr_data_q;
    assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_updsllr_qpsk_llr_calc.sv
// Directed bench for updsllr_qpsk_llr_calc with hand-computed LLR words.

module tb_updsllr_qpsk_llr_calc;
    logic        i_core_clk = 1'b0;
    logic        i_rx_rst, i_start, i_data_strobe;
    logic [15:0] i_cur_user_re_amounts;
    logic [15:0] i_re0_data_i, i_re0_data_q, i_re1_data_i, i_re1_data_q, i_noise_data;
    logic        o_llr_valid, o_llr_last, o_busy;
    logic [31:0] o_llr_data;
`ifdef UPDSLLR_SAT_CNT_EN
    logic [15:0] o_sat_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 i_core_clk = ~i_core_clk;

    updsllr_qpsk_llr_calc dut (
        .i_core_clk            (i_core_clk),
        .i_rx_rst              (i_rx_rst),
        .i_start               (i_start),
        .i_cur_user_re_amounts (i_cur_user_re_amounts),
        .i_data_strobe         (i_data_strobe),
        .i_re0_data_i          (i_re0_data_i),
        .i_re0_data_q          (i_re0_data_q),
        .i_re1_data_i          (i_re1_data_i),
        .i_re1_data_q          (i_re1_data_q),
        .i_noise_data          (i_noise_data),
        .o_llr_valid           (o_llr_valid),
        .o_llr_data            (o_llr_data),
        .o_llr_last            (o_llr_last),
        .o_busy                (o_busy)
`ifdef UPDSLLR_SAT_CNT_EN
        ,
        .o_sat_cnt             (o_sat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_core_clk);
        #1;
    endtask

    task automatic set_re(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] d, input logic [15:0] n);
        i_re0_data_i = a;
        i_re0_data_q = b;
        i_re1_data_i = c;
        i_re1_data_q = d;
        i_noise_data = n;
    endtask

    task automatic start(input logic [15:0] amt);
        i_start = 1'b1;
        i_cur_user_re_amounts = amt;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        int nv, nl, first_v, last_v, last_idx, stray;
        i_rx_rst = 1'b1;
        i_start = 1'b0;
        i_data_strobe = 1'b0;
        i_cur_user_re_amounts = '0;
        set_re(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        i_rx_rst = 1'b0;
        chk("rst_valid", o_llr_valid, 0);
        chk("rst_last", o_llr_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_llr_data, 0);
`ifdef UPDSLLR_SAT_CNT_EN
        chk("rst_satcnt", o_sat_cnt, 0);
`endif

        // Basic: one pair, amount 2
        start(16'd2);
        chk("basic_busy", o_busy, 1);
        set_re(16'h0100, 16'hFF00, 16'h0000, 16'h0040, 16'h0080);
        i_data_strobe = 1'b1;
        tick();
        i_data_strobe = 1'b0;
        tick();
        chk("basic_early", o_llr_valid, 0);
        tick();
        chk("basic_valid", o_llr_valid, 1);
        chk("basic_last", o_llr_last, 1);
        chk("basic_data", o_llr_data, 32'h0800E020);
        chk("basic_busy_drop", o_busy, 0);
        tick();
        chk("basic_valid_off", o_llr_valid, 0);
        chk("basic_hold", o_llr_data, 32'h0800E020);

        // Saturation and floor
        start(16'd2);
        set_re(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF);
        i_data_strobe = 1'b1;
        tick();
        i_data_strobe = 1'b0;
        tick();
        tick();
        chk("sat_valid", o_llr_valid, 1);
        chk("sat_data", o_llr_data, 32'hC03F807F);
`ifdef UPDSLLR_SAT_CNT_EN
        chk("sat_cnt", o_sat_cnt, 2);
`endif
        tick();

        // Streaming: 900 back-to-back pairs
        start(16'd1800);
        set_re(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0080);
        nv = 0; nl = 0; first_v = -1; last_v = -1; last_idx = -1;
        for (int i = 0; i < 905; i++) begin
            i_data_strobe = (i < 900);
            tick();
            if (o_llr_valid) begin
                nv++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
            if (o_llr_last) begin
                nl++;
                last_idx = i;
            end
        end
        chk("stream_nvalid", nv, 900);
        chk("stream_first", first_v, 2);
        chk("stream_span", last_v - first_v + 1, 900);
        chk("stream_nlast", nl, 1);
        chk("stream_last_idx", last_idx, 901);
        chk("stream_data", o_llr_data, 32'h20202020);
        chk("stream_busy", o_busy, 0);

        // Odd amount: re1 of final word zeroed
        start(16'd3);
        i_data_strobe = 1'b1;
        tick();
        tick();
        i_data_strobe = 1'b0;
        tick();
        chk("odd_w1_valid", o_llr_valid, 1);
        chk("odd_w1_last", o_llr_last, 0);
        chk("odd_w1_data", o_llr_data, 32'h20202020);
        tick();
        chk("odd_w2_valid", o_llr_valid, 1);
        chk("odd_w2_last", o_llr_last, 1);
        chk("odd_w2_data", o_llr_data, 32'h00002020);
        tick();

        // Ignored strobes: IDLE, coincident with start, DRAIN; start during RUN
        set_re(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0080);
        i_data_strobe = 1'b1;
        tick();
        i_data_strobe = 1'b0;
        tick();
        tick();
        chk("idle_strobe", o_llr_valid, 0);
        i_data_strobe = 1'b1;
        start(16'd4);
        i_data_strobe = 1'b0;
        tick();
        tick();
        chk("start_strobe", o_llr_valid, 0);
        chk("start_busy", o_busy, 1);
        start(16'd2);
        i_data_strobe = 1'b1;
        tick();
        tick();
        tick();
        chk("run_w1_valid", o_llr_valid, 1);
        chk("run_w1_last", o_llr_last, 0);
        chk("run_w1_data", o_llr_data, 32'h08080808);
        i_data_strobe = 1'b0;
        tick();
        chk("run_w2_last", o_llr_last, 1);
        chk("run_w2_busy", o_busy, 0);
        tick();
        chk("drain_strobe", o_llr_valid, 0);

        // Reset mid-user
        start(16'd4);
        set_re(16'h0100, 16'hFF00, 16'h0000, 16'h0040, 16'h0080);
        i_data_strobe = 1'b1;
        tick();
        i_data_strobe = 1'b0;
        i_rx_rst = 1'b1;
        tick();
        i_rx_rst = 1'b0;
        chk("mrst_data", o_llr_data, 0);
        chk("mrst_busy", o_busy, 0);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_llr_valid || o_llr_last) stray++;
            tick();
        end
        chk("mrst_stray", stray, 0);
        start(16'd2);
        i_data_strobe = 1'b1;
        tick();
        i_data_strobe = 1'b0;
        tick();
        tick();
        chk("restart_valid", o_llr_valid, 1);
        chk("restart_last", o_llr_last, 1);
        chk("restart_data", o_llr_data, 32'h0800E020);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
